funnel_window_feeder: RTL and testbench

Streaming front end for the 10-bit right funnel shifter. It accepts 10-bit words from an upstream valid/ready source and holds a two-word bit window. It tracks a bit offset (0..9) and drives the shifter's in1/in2/amt operands so that the shifter output is always the next 10 unconsumed stream bits. The stream is LSB-first, with the older word in in2 and the newer word in in1. A downstream consumer retires 0..10 bits per cycle. When the offset crosses a word boundary, the block retires the old word and refills the window from upstream in the same cycle.

---
 rtl/funnel_window_feeder.sv | 114 +++++++++++
 tb/tb_funnel_window_feeder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/funnel_window_feeder.sv
// Two-word bit window feeding a W-bit right funnel shifter from a valid/ready word stream.
// Tracks the bit offset into the window, and retires and refills a word whenever the offset wraps.
module funnel_window_feeder #(
  parameter int W  = 10,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          consume,
  input  logic [AW-1:0] consume_len,
  input  logic          flush,
  output logic          win_valid,
  output logic [W-1:0]  sh_in1,
  output logic [W-1:0]  sh_in2,
  output logic [AW-1:0] sh_amt,
  output logic          len_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [AW-1:0] W_AW = AW'(W);
  localparam logic [AW:0]   W_N  = (AW+1)'(W);

  state_e        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [AW-1:0] off_q, off_d;
  logic          len_err_q, len_err_d;

  logic          acc_c;
  logic          over;
  logic          wrap;
  logic          push;
  logic [AW-1:0] len_eff;
  logic [AW:0]   n;

  always_comb begin
    acc_c   = consume && (state_q == FULL);
    over    = consume_len > W_AW;
    len_eff = over ? W_AW : consume_len;
    n       = {1'b0, off_q} + {1'b0, len_eff};
    wrap    = acc_c && (n >= W_N);
    s_ready = !flush && ((state_q != FULL) || wrap);
    push    = s_valid && s_ready;

    state_d   = state_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    off_d     = off_q;
    len_err_d = len_err_q;

    if (flush) begin
      state_d   = EMPTY;
      off_d     = '0;
      len_err_d = 1'b0;
    end else begin
      if (acc_c) begin
        if (over) len_err_d = 1'b1;
        if (wrap) begin
          off_d = AW'(n - W_N);
          lo_d  = hi_q;
        end else begin
          off_d = n[AW-1:0];
        end
      end
      // A wrap drops the old word first, so FULL only stays FULL if a refill lands in the same cycle.
      unique case (state_q)
        EMPTY: if (push) begin
          state_d = HALF;
          lo_d    = s_data;
        end
        HALF: if (push) begin
          state_d = FULL;
          hi_d    = s_data;
        end
        FULL: if (wrap) begin
          if (push) hi_d = s_data;
          else      state_d = HALF;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      lo_q      <= '0;
      hi_q      <= '0;
      off_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      off_q     <= off_d;
      len_err_q <= len_err_d;
    end
  end

  assign win_valid = (state_q == FULL);
  assign sh_in1    = hi_q;
  assign sh_in2    = lo_q;
  assign sh_amt    = off_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_funnel_window_feeder.sv
// Scoreboard bench: a word-queue / bit-queue reference model predicts every cycle, and monitors compare the DUT.
module tb_funnel_window_feeder;
  localparam int W  = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic          consume;
  logic [AW-1:0] consume_len;
  logic          flush;
  logic          win_valid;
  logic [W-1:0]  sh_in1;
  logic [W-1:0]  sh_in2;
  logic [AW-1:0] sh_amt;
  logic          len_err;

  funnel_window_feeder #(.W(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .consume(consume), .consume_len(consume_len), .flush(flush), .win_valid(win_valid),
    .sh_in1(sh_in1), .sh_in2(sh_in2), .sh_amt(sh_amt), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wv;
    logic         half;
    logic [3:0]   amt;
    logic         lerr;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] fun;
  } exp_t;

  exp_t exp_q[$];
  logic rdy_q[$];

  // Reference model: words held, bit offset into the oldest word, unconsumed stream bits.
  logic [W-1:0] wq[$];
  int           m_off;
  logic         m_lerr;
  bit           bq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    bq.delete();
    m_off  = 0;
    m_lerr = 1'b0;
  endtask

  task automatic cycle(input logic fl, input logic co, input logic [AW-1:0] len,
                       input logic sv, input logic [W-1:0] d);
    bit   full, acc, wrap, rdy, push;
    int   l, n;
    exp_t e;
    @(negedge clk);
    flush = fl; consume = co; consume_len = len; s_valid = sv; s_data = d;
    full = (wq.size() == 2);
    acc  = co && full;
    l    = (int'(len) > W) ? W : int'(len);
    n    = m_off + l;
    wrap = acc && (n >= W);
    rdy  = !fl && (!full || wrap);
    push = sv && rdy;
    rdy_q.push_back(rdy);
    if (fl) begin
      wq.delete();
      bq.delete();
      m_off  = 0;
      m_lerr = 1'b0;
    end else begin
      if (acc) begin
        if (int'(len) > W) m_lerr = 1'b1;
        for (int i = 0; i < l; i++) void'(bq.pop_front());
        if (wrap) begin
          m_off = n - W;
          void'(wq.pop_front());
        end else begin
          m_off = n;
        end
      end
      if (push) begin
        wq.push_back(d);
        for (int i = 0; i < W; i++) bq.push_back(d[i]);
      end
    end
    e.wv   = (wq.size() == 2);
    e.half = (wq.size() == 1);
    e.amt  = 4'(m_off);
    e.lerr = m_lerr;
    e.in2  = (wq.size() >= 1) ? wq[0] : '0;
    e.in1  = (wq.size() == 2) ? wq[1] : '0;
    e.fun  = '0;
    for (int i = 0; i < W; i++) if (i < bq.size()) e.fun[i] = bq[i];
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 1);
    chk({tag, "_win_valid"}, 32'(win_valid), 0);
    chk({tag, "_sh_in1"}, 32'(sh_in1), 0);
    chk({tag, "_sh_in2"}, 32'(sh_in2), 0);
    chk({tag, "_sh_amt"}, 32'(sh_amt), 0);
    chk({tag, "_len_err"}, 32'(len_err), 0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear with no edge in between.
  task automatic mid_reset();
    @(negedge clk);
    #3;
    flush = 0; consume = 0; consume_len = '0; s_valid = 0; s_data = '0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // s_ready monitor: combinational response to the inputs driven this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rdy_q.size() > 0) chk("s_ready", 32'(s_ready), 32'(rdy_q.pop_front()));
    end
  end

  // Window monitor: registered state after each clock edge.
  initial begin
    exp_t e;
    logic [2*W-1:0] cat;
    logic [W-1:0]   fun;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("win_valid", 32'(win_valid), 32'(e.wv));
        chk("sh_amt", 32'(sh_amt), 32'(e.amt));
        chk("len_err", 32'(len_err), 32'(e.lerr));
        if (e.wv || e.half) chk("sh_in2", 32'(sh_in2), 32'(e.in2));
        if (e.wv) begin
          chk("sh_in1", 32'(sh_in1), 32'(e.in1));
          cat = {sh_in1, sh_in2} >> sh_amt;
          fun = cat[W-1:0];
          chk("next_bits", 32'(fun), 32'(e.fun));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 0; consume = 0; consume_len = '0; s_valid = 0; s_data = '0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cycle(0, 0, 4'd0,  1, 10'h001);
    cycle(0, 0, 4'd0,  1, 10'h002);
    cycle(0, 1, 4'd1,  0, 10'h000);
    cycle(0, 1, 4'd8,  0, 10'h000);
    cycle(0, 1, 4'd3,  1, 10'h3FF);
    cycle(0, 1, 4'd3,  0, 10'h000);
    cycle(0, 1, 4'd10, 0, 10'h000);
    cycle(0, 1, 4'd4,  0, 10'h000);
    cycle(0, 0, 4'd0,  1, 10'h201);
    cycle(0, 1, 4'd5,  0, 10'h000);
    cycle(0, 0, 4'd0,  1, 10'h123);
    cycle(0, 1, 4'd12, 1, 10'h0AB);
    cycle(0, 1, 4'd0,  1, 10'h0CD);
    cycle(0, 1, 4'd4,  1, 10'h0EF);
    cycle(0, 1, 4'd7,  1, 10'h111);
    cycle(1, 1, 4'd2,  1, 10'h155);
    cycle(0, 0, 4'd0,  1, 10'h2AA);
    cycle(0, 0, 4'd0,  1, 10'h0F0);
    cycle(0, 1, 4'd4,  0, 10'h000);
    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      logic          fl, co, sv;
      logic [AW-1:0] len;
      fl  = ($urandom_range(0, 99) < 2);
      co  = ($urandom_range(0, 99) < 65);
      sv  = ($urandom_range(0, 99) < 75);
      len = ($urandom_range(0, 99) < 8) ? AW'($urandom_range(11, 15))
                                        : AW'($urandom_range(0, W));
      cycle(fl, co, len, sv, W'($urandom_range(0, 1023)));
      if (i % 1000 == 999) mid_reset();
    end

    cycle(0, 0, 4'd0, 0, 10'h000);
    cycle(0, 0, 4'd0, 0, 10'h000);
    @(posedge clk);
    #3;
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("rdy_q_drained", 32'(rdy_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
